// File: rtl/ex_mem_stage.sv
// ex_mem_stage: EX->MEM pipeline register with branch resolution.
// Stage A holds the EX control bundle for the cycle the ALU is computing, so
// the ALU's registered result lines up with it. Stage M is the EX/MEM register.
// Optional feature macro: EX_MEM_BNE_EN adds the ex_branch_ne input (BNE support).
module ex_mem_stage #(
  parameter int DATA_W = 16,
  parameter int RD_W   = 3
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              ex_valid,
  input  logic              ex_reg_write,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic              ex_mem_to_reg,
  input  logic              ex_branch,
`ifdef EX_MEM_BNE_EN
  input  logic              ex_branch_ne,
`endif
  input  logic [RD_W-1:0]   ex_rd,
  input  logic [DATA_W-1:0] ex_store_data,
  input  logic [DATA_W-1:0] ex_pc_next,
  input  logic [DATA_W-1:0] ex_imm,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  input  logic              hold,
  input  logic              flush,
  output logic              mem_valid,
  output logic              mem_reg_write,
  output logic              mem_mem_read,
  output logic              mem_mem_write,
  output logic              mem_mem_to_reg,
  output logic [RD_W-1:0]   mem_rd,
  output logic [DATA_W-1:0] mem_alu_result,
  output logic [DATA_W-1:0] mem_store_data,
  output logic              branch_taken,
  output logic [DATA_W-1:0] branch_target
);

  // Stage A (align)
  logic              r_a_valid, r_a_reg_write, r_a_mem_read, r_a_mem_write;
  logic              r_a_mem_to_reg, r_a_branch;
  logic [RD_W-1:0]   r_a_rd;
  logic [DATA_W-1:0] r_a_store_data, r_a_target;
`ifdef EX_MEM_BNE_EN
  logic              r_a_branch_ne;
`endif

  // Stage M (capture)
  logic              r_m_valid, r_m_reg_write, r_m_mem_read, r_m_mem_write;
  logic              r_m_mem_to_reg;
  logic [RD_W-1:0]   r_m_rd;
  logic [DATA_W-1:0] r_m_alu_result, r_m_store_data;

  // Redirect
  logic              r_taken;
  logic [DATA_W-1:0] r_target;

  logic              w_cond, w_take, w_advance;
  logic [DATA_W-1:0] w_target;

  // Offset is in halfwords; the sum wraps mod 2^DATA_W.
  assign w_target  = ex_pc_next + {ex_imm[DATA_W-2:0], 1'b0};
`ifdef EX_MEM_BNE_EN
  assign w_cond    = r_a_branch_ne ? ~alu_zero : alu_zero;
`else
  assign w_cond    = alu_zero;
`endif
  assign w_take    = r_a_valid & r_a_branch & w_cond;
  assign w_advance = ~flush & ~hold;

  // Stage A: sample the EX bundle; a resolving taken branch kills the younger entry
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_a_valid      <= 1'b0;
      r_a_reg_write  <= 1'b0;
      r_a_mem_read   <= 1'b0;
      r_a_mem_write  <= 1'b0;
      r_a_mem_to_reg <= 1'b0;
      r_a_branch     <= 1'b0;
      r_a_rd         <= '0;
      r_a_store_data <= '0;
      r_a_target     <= '0;
`ifdef EX_MEM_BNE_EN
      r_a_branch_ne  <= 1'b0;
`endif
    end else if (flush) begin
      r_a_valid      <= 1'b0;
    end else if (!hold) begin
      r_a_valid      <= ex_valid & ~w_take;
      r_a_reg_write  <= ex_reg_write;
      r_a_mem_read   <= ex_mem_read;
      r_a_mem_write  <= ex_mem_write;
      r_a_mem_to_reg <= ex_mem_to_reg;
      r_a_branch     <= ex_branch;
      r_a_rd         <= ex_rd;
      r_a_store_data <= ex_store_data;
      r_a_target     <= w_target;
`ifdef EX_MEM_BNE_EN
      r_a_branch_ne  <= ex_branch_ne;
`endif
    end
  end

  // Stage M: move A forward together with the ALU result now valid for it
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_m_valid      <= 1'b0;
      r_m_reg_write  <= 1'b0;
      r_m_mem_read   <= 1'b0;
      r_m_mem_write  <= 1'b0;
      r_m_mem_to_reg <= 1'b0;
      r_m_rd         <= '0;
      r_m_alu_result <= '0;
      r_m_store_data <= '0;
    end else if (flush) begin
      r_m_valid      <= 1'b0;
    end else if (!hold) begin
      r_m_valid      <= r_a_valid;
      r_m_reg_write  <= r_a_reg_write;
      r_m_mem_read   <= r_a_mem_read;
      r_m_mem_write  <= r_a_mem_write;
      r_m_mem_to_reg <= r_a_mem_to_reg;
      r_m_rd         <= r_a_rd;
      r_m_alu_result <= alu_result;
      r_m_store_data <= r_a_store_data;
    end
  end

  // Redirect: one-cycle pulse; target is kept until the next taken branch
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_taken  <= 1'b0;
      r_target <= '0;
    end else begin
      r_taken <= w_take & w_advance;
      if (w_take & w_advance) r_target <= r_a_target;
    end
  end

  assign mem_valid      = r_m_valid;
  assign mem_reg_write  = r_m_valid & r_m_reg_write;
  assign mem_mem_read   = r_m_valid & r_m_mem_read;
  assign mem_mem_write  = r_m_valid & r_m_mem_write;
  assign mem_mem_to_reg = r_m_valid & r_m_mem_to_reg;
  assign mem_rd         = r_m_rd;
  assign mem_alu_result = r_m_alu_result;
  assign mem_store_data = r_m_store_data;
  assign branch_taken   = r_taken;
  assign branch_target  = r_target;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Bench for ex_mem_stage: directed scenarios plus randomized traffic, all
// compared against an instruction-level reference model every cycle.
module tb_ex_mem_stage;
  localparam int DW = 16;
  localparam int RW = 3;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset_n, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch;
`ifdef EX_MEM_BNE_EN
  logic ex_branch_ne;
`endif
  logic [RW-1:0] ex_rd;
  logic [DW-1:0] ex_store_data, ex_pc_next, ex_imm, alu_result;
  logic alu_zero, hold, flush;
  logic mem_valid, mem_reg_write, mem_mem_read, mem_mem_write, mem_mem_to_reg;
  logic [RW-1:0] mem_rd;
  logic [DW-1:0] mem_alu_result, mem_store_data, branch_target;
  logic branch_taken;

  ex_mem_stage #(.DATA_W(DW), .RD_W(RW)) dut (
    .clock(clock), .reset_n(reset_n), .ex_valid(ex_valid),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_branch(ex_branch),
`ifdef EX_MEM_BNE_EN
    .ex_branch_ne(ex_branch_ne),
`endif
    .ex_rd(ex_rd), .ex_store_data(ex_store_data), .ex_pc_next(ex_pc_next), .ex_imm(ex_imm),
    .alu_result(alu_result), .alu_zero(alu_zero), .hold(hold), .flush(flush),
    .mem_valid(mem_valid), .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
    .mem_mem_write(mem_mem_write), .mem_mem_to_reg(mem_mem_to_reg), .mem_rd(mem_rd),
    .mem_alu_result(mem_alu_result), .mem_store_data(mem_store_data),
    .branch_taken(branch_taken), .branch_target(branch_target)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: one in-flight record per instruction
  typedef struct {
    bit v, rw, mr, mw, m2r, br, bne;
    int rd, st, tgt, alu;
  } ins_t;

  ins_t ref_ex;   // sampled, waiting for its ALU result
  ins_t ref_mem;  // visible on the mem_* outputs
  bit   ref_taken;
  int   ref_tgt;

  function automatic bit cur_bne();
`ifdef EX_MEM_BNE_EN
    return ex_branch_ne;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_edge();
    ins_t nw;
    bit   take;
    if (!reset_n) begin
      ref_ex = '{default: 0}; ref_mem = '{default: 0};
      ref_taken = 0; ref_tgt = 0;
    end else if (flush) begin
      ref_ex.v = 0; ref_mem.v = 0; ref_taken = 0;
    end else if (hold) begin
      ref_taken = 0;
    end else begin
      take = ref_ex.v && ref_ex.br && (ref_ex.bne ? !alu_zero : alu_zero);
      ref_mem = ref_ex;
      ref_mem.alu = alu_result;
      nw.v = ex_valid && !take;
      nw.rw = ex_reg_write; nw.mr = ex_mem_read; nw.mw = ex_mem_write;
      nw.m2r = ex_mem_to_reg; nw.br = ex_branch; nw.bne = cur_bne();
      nw.rd = ex_rd; nw.st = ex_store_data; nw.alu = 0;
      nw.tgt = (int'(ex_pc_next) + 2 * int'(ex_imm)) % 65536;
      if (take) ref_tgt = ref_ex.tgt;
      ref_taken = take;
      ref_ex = nw;
    end
  endtask

  task automatic compare();
    chk("mem_valid", mem_valid, ref_mem.v);
    chk("mem_reg_write", mem_reg_write, ref_mem.v && ref_mem.rw);
    chk("mem_mem_read", mem_mem_read, ref_mem.v && ref_mem.mr);
    chk("mem_mem_write", mem_mem_write, ref_mem.v && ref_mem.mw);
    if (ref_mem.v) begin
      chk("mem_mem_to_reg", mem_mem_to_reg, ref_mem.m2r);
      chk("mem_rd", mem_rd, ref_mem.rd);
      chk("mem_alu_result", mem_alu_result, ref_mem.alu);
      chk("mem_store_data", mem_store_data, ref_mem.st);
    end
    chk("branch_taken", branch_taken, ref_taken);
    if (ref_taken) chk("branch_target", branch_target, ref_tgt);
  endtask

  task automatic cycle();
    @(posedge clock);
    model_edge();
    @(negedge clock);
    compare();
  endtask

  task automatic set_ins(input bit v, input bit rw, input bit br, input int rd,
                         input int pc, input int imm);
    ex_valid = v; ex_reg_write = rw; ex_mem_read = 0; ex_mem_write = 0;
    ex_mem_to_reg = 0; ex_branch = br; ex_rd = RW'(rd);
    ex_store_data = DW'($urandom); ex_pc_next = DW'(pc); ex_imm = DW'(imm);
`ifdef EX_MEM_BNE_EN
    ex_branch_ne = 0;
`endif
  endtask

  task automatic rand_inputs();
    ex_valid = 1'($urandom); ex_reg_write = 1'($urandom); ex_mem_read = 1'($urandom);
    ex_mem_write = 1'($urandom); ex_mem_to_reg = 1'($urandom);
    ex_branch = ($urandom % 4 == 0); ex_rd = RW'($urandom);
    ex_store_data = DW'($urandom); ex_pc_next = DW'($urandom); ex_imm = DW'($urandom);
    alu_result = DW'($urandom); alu_zero = 1'($urandom);
`ifdef EX_MEM_BNE_EN
    ex_branch_ne = 1'($urandom);
`endif
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, mem_valid, 0);
    chk({tag, "_ctl"}, {mem_reg_write, mem_mem_read, mem_mem_write, mem_mem_to_reg}, 0);
    chk({tag, "_rd"}, mem_rd, 0);
    chk({tag, "_alu"}, mem_alu_result, 0);
    chk({tag, "_st"}, mem_store_data, 0);
    chk({tag, "_taken"}, branch_taken, 0);
    chk({tag, "_target"}, branch_target, 0);
  endtask

  initial begin
    reset_n = 0; hold = 0; flush = 0;
    // Reset with random inputs for 3 cycles
    for (int i = 0; i < 3; i++) begin
      rand_inputs(); hold = 1'($urandom); flush = 1'($urandom);
      cycle();
      chk_all_zero("reset");
    end
    hold = 0; flush = 0; reset_n = 1;

    // First ADD after release
    set_ins(1, 1, 0, 3, 0, 0); alu_result = DW'($urandom); alu_zero = 0;
    cycle();
    chk("add_early_valid", mem_valid, 0);
    set_ins(0, 0, 0, 0, 0, 0); alu_result = 16'h0012;
    cycle();
    chk("add_valid", mem_valid, 1);
    chk("add_rd", mem_rd, 3);
    chk("add_alu", mem_alu_result, 16'h0012);

    // Streaming 4 results without bubbles
    for (int i = 1; i <= 4; i++) begin
      set_ins(1, 1, 0, i, 0, 0); alu_result = DW'(i - 1);
      cycle();
      if (i >= 2) begin
        chk("stream_valid", mem_valid, 1);
        chk("stream_alu", mem_alu_result, i - 1);
      end
    end
    set_ins(0, 0, 0, 0, 0, 0); alu_result = 16'h0004;
    cycle();
    chk("stream_valid", mem_valid, 1);
    chk("stream_alu", mem_alu_result, 4);

    // Taken BEQ
    set_ins(1, 0, 1, 0, 16'h0010, 16'h0004); alu_zero = 0;
    cycle();
    set_ins(1, 1, 0, 5, 0, 0); alu_result = 0; alu_zero = 1;
    cycle();
    chk("beq_taken", branch_taken, 1);
    chk("beq_target", branch_target, 16'h0018);
    set_ins(0, 0, 0, 0, 0, 0); alu_zero = 0;
    cycle();
    chk("beq_killed_valid", mem_valid, 0);
    chk("beq_pulse_end", branch_taken, 0);

    // Not-taken BEQ
    set_ins(1, 0, 1, 0, 16'h0020, 16'h0008);
    cycle();
    set_ins(1, 1, 0, 6, 0, 0); alu_result = 16'h0005; alu_zero = 0;
    cycle();
    chk("bnt_taken", branch_taken, 0);
    set_ins(0, 0, 0, 0, 0, 0); alu_result = 16'h0077;
    cycle();
    chk("bnt_taken2", branch_taken, 0);
    chk("bnt_next_valid", mem_valid, 1);
    chk("bnt_next_rd", mem_rd, 6);

    // Target wrap
    set_ins(1, 0, 1, 0, 16'hFFFE, 16'h0002);
    cycle();
    set_ins(0, 0, 0, 0, 0, 0); alu_zero = 1;
    cycle();
    chk("wrap_taken", branch_taken, 1);
    chk("wrap_target", branch_target, 16'h0002);
    alu_zero = 0;
    cycle();

    // Hold for 2 cycles mid-stream
    set_ins(1, 1, 0, 1, 0, 0); alu_result = 0;
    cycle();
    set_ins(1, 1, 0, 2, 0, 0); alu_result = 16'h0011;
    cycle();
    hold = 1; set_ins(1, 1, 0, 7, 0, 0); alu_result = 16'h0022;
    cycle();
    chk("hold_rd", mem_rd, 1);
    chk("hold_alu", mem_alu_result, 16'h0011);
    cycle();
    chk("hold_rd2", mem_rd, 1);
    hold = 0; set_ins(1, 1, 0, 3, 0, 0);
    cycle();
    chk("resume_rd", mem_rd, 2);
    chk("resume_alu", mem_alu_result, 16'h0022);
    set_ins(0, 0, 0, 0, 0, 0); alu_result = 16'h0033;
    cycle();
    chk("resume_rd2", mem_rd, 3);
    chk("resume_alu2", mem_alu_result, 16'h0033);

    // Flush together with hold empties both stages
    set_ins(1, 1, 0, 4, 0, 0);
    cycle();
    set_ins(1, 1, 0, 5, 0, 0); flush = 1; hold = 1;
    cycle();
    chk("flush_valid", mem_valid, 0);
    flush = 0; hold = 0; set_ins(0, 0, 0, 0, 0, 0);
    cycle();
    chk("flush_a_empty", mem_valid, 0);

`ifdef EX_MEM_BNE_EN
    // BNE taken when zero=0
    set_ins(1, 0, 1, 0, 16'h0040, 16'h0001); ex_branch_ne = 1;
    cycle();
    set_ins(0, 0, 0, 0, 0, 0); alu_zero = 0;
    cycle();
    chk("bne_taken", branch_taken, 1);
    chk("bne_target", branch_target, 16'h0042);
    cycle();
    // BNE not taken when zero=1
    set_ins(1, 0, 1, 0, 16'h0050, 16'h0001); ex_branch_ne = 1;
    cycle();
    set_ins(0, 0, 0, 0, 0, 0); alu_zero = 1;
    cycle();
    chk("bne_not_taken", branch_taken, 0);
    alu_zero = 0;
    cycle();
`endif

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      rand_inputs();
      reset_n = ($urandom % 50 != 0);
      flush = ($urandom % 20 == 0);
      hold = ($urandom % 8 == 0);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
